decade_chain_ctrl: RTL and testbench

//  Run-control sequencer for a cascade of NDIG decade (0-9) counter digits.

---
 rtl/decade_pkg.sv | 18 +
 rtl/decade_chain_ctrl_if.sv | 29 ++
 rtl/decade_digit.sv | 25 ++
 rtl/decade_chain_ctrl.sv | 99 +++++++++
 tb/tb_decade_chain_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/decade_pkg.sv
// Shared state encoding and BCD constants for the decade counter chain.
package decade_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/decade_chain_ctrl_if.sv
// Command, target and status bundle between board command logic and the counter chain.
interface decade_chain_ctrl_if
    import decade_pkg::*;
#(
    parameter int NDIG = 2
) ();
    // Commands are levels sampled every clock; there is no valid/ready handshake,
    // so the master must hold or pulse them synchronously to clk.
    logic              start;
    logic              stop;
    logic              clear;
    logic              count_in;
    logic [4*NDIG-1:0] target;
    logic [4*NDIG-1:0] digits;
    logic              busy;
    logic              done;
    logic              overflow;
    state_t            state;

    modport master (
        output start, stop, clear, count_in, target,
        input  digits, busy, done, overflow, state
    );

    modport slave (
        input  start, stop, clear, count_in, target,
        output digits, busy, done, overflow, state
    );
endinterface

// File: rtl/decade_digit.sv
// One BCD digit (0-9) with synchronous clear and a terminal-count flag at 9.
module decade_digit
    import decade_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] q,
    output logic             tc
);

    assign tc = (q == BCD_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= tc ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/decade_chain_ctrl.sv
// Run-control FSM over NDIG cascaded BCD digits with terminal match and sticky wrap flag.
module decade_chain_ctrl
    import decade_pkg::*;
#(
    parameter int NDIG = 2
) (
    input logic               clk,
    input logic               rst_n,
    decade_chain_ctrl_if.slave bus
);

    state_t            state;
    logic              busy_r;
    logic              done_r;
    logic              ovf_r;
    logic              inc;
    logic              wrap;
    logic              tgt_ok;
    logic              match;
    logic [NDIG-1:0]   tc;
    logic [NDIG:0]     carry;
    logic [4*NDIG-1:0] q;
    logic [4*NDIG-1:0] nxt;

    // Start outranks stop, so a RUN cycle with both still counts.
    assign inc = (state == ST_RUN) && !bus.clear && (bus.start || !bus.stop) && bus.count_in;

    assign carry[0] = inc;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        decade_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (bus.clear),
            .en    (carry[i]),
            .q     (q[4*i +: 4]),
            .tc    (tc[i])
        );
        assign carry[i+1]    = carry[i] & tc[i];
        assign nxt[4*i +: 4] = carry[i] ? (tc[i] ? 4'd0 : q[4*i +: 4] + 4'd1) : q[4*i +: 4];
    end

    assign wrap = carry[NDIG];

    always_comb begin
        tgt_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (!bcd_ok(bus.target[4*i +: 4])) tgt_ok = 1'b0;
        end
    end

    // On a match the digits already land on the target, so no separate load is needed.
    assign match = inc && tgt_ok && (nxt == bus.target);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.clear) begin
                state  <= ST_IDLE;
                busy_r <= 1'b0;
                ovf_r  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_PAUSE, ST_DONE: begin
                        if (bus.start) begin
                            state  <= ST_RUN;
                            busy_r <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (!bus.start && bus.stop) begin
                            state <= ST_PAUSE;
                        end else if (inc) begin
                            if (wrap) ovf_r <= 1'b1;
                            if (match) begin
                                state  <= ST_DONE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.digits   = q;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = ovf_r;
    assign bus.state    = state;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Directed and random stimulus for decade_chain_ctrl against an integer-count reference model.
module tb_decade_chain_ctrl;
    import decade_pkg::*;

    localparam int NDIG = 2;
    localparam int W    = 4 * NDIG;
    localparam int MODN = 100;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decade_chain_ctrl_if #(.NDIG(NDIG)) bus ();

    decade_chain_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] tgt;
    logic [W-1:0] exp_digits;
    int m_cnt = 0;
    int m_st = M_IDLE;
    bit m_ovf = 1'b0;
    bit m_done = 1'b0;
    int done_seen = 0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Returns -1 when any nibble is not a decimal digit.
    function automatic int tgt_value(input logic [W-1:0] b);
        int v;
        int s;
        v = 0;
        s = 1;
        for (int i = 0; i < NDIG; i++) begin
            if (b[4*i +: 4] > 4'd9) return -1;
            v = v + int'(b[4*i +: 4]) * s;
            s = s * 10;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit cl, input bit st, input bit sp, input bit ci);
        if (!r) begin
            m_st = M_IDLE; m_cnt = 0; m_ovf = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (cl) begin
                m_st = M_IDLE; m_cnt = 0; m_ovf = 0;
            end else if (m_st != M_RUN) begin
                if (st) m_st = M_RUN;
            end else if (!st && sp) begin
                m_st = M_PAUSE;
            end else if (ci) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == MODN) begin
                    m_cnt = 0;
                    m_ovf = 1;
                end
                if (tgt_value(tgt) == m_cnt) begin
                    m_st = M_DONE;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit cl, input bit st, input bit sp, input bit ci);
        rst_n = r; bus.clear = cl; bus.start = st; bus.stop = sp; bus.count_in = ci;
        bus.target = tgt;
        @(posedge clk);
        model(r, cl, st, sp, ci);
        exp_q.push_back(to_bcd(m_cnt));
        #1;
        exp_digits = exp_q.pop_front();
        check("digits", 32'(bus.digits), 32'(exp_digits));
        check("busy", 32'(bus.busy), 32'(m_st == M_RUN || m_st == M_PAUSE));
        check("done", 32'(bus.done), 32'(m_done));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("state", 32'(bus.state), 32'(m_st));
        if (bus.done) done_seen++;
    endtask

    task automatic counts(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 1);
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.clear = 0; bus.count_in = 0;
        tgt = 8'hFF; bus.target = tgt;

        // Reset overrides start/count_in
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        check("rst_digits", 32'(bus.digits), 32'h00);
        check("rst_busy", 32'(bus.busy), 32'h0);
        cycle(1, 0, 0, 0, 0);

        // Terminal match at 15
        tgt = 8'h15;
        cycle(1, 0, 1, 0, 0);
        counts(15);
        check("t2_digits", 32'(bus.digits), 32'h15);
        check("t2_done", 32'(bus.done), 32'h1);
        counts(3);
        check("t2_hold", 32'(bus.digits), 32'h15);
        check("t2_done_low", 32'(bus.done), 32'h0);
        check("t2_state", 32'(bus.state), 32'(ST_DONE));

        // Digit carry, pause, resume
        tgt = 8'hFF;
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        counts(10);
        check("t3_carry", 32'(bus.digits), 32'h10);
        cycle(1, 0, 0, 1, 1);
        counts(5);
        check("t3_paused", 32'(bus.digits), 32'h10);
        cycle(1, 0, 1, 0, 0);
        counts(1);
        check("t3_resume", 32'(bus.digits), 32'h11);

        // Invalid target free-runs and wraps
        tgt = 8'hA0;
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        done_seen = 0;
        counts(100);
        check("t4_wrap", 32'(bus.digits), 32'h00);
        check("t4_ovf", 32'(bus.overflow), 32'h1);
        check("t4_no_done", 32'(done_seen), 32'h0);

        // Target zero matches on the wrap edge
        tgt = 8'h00;
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        counts(99);
        check("t0_99", 32'(bus.digits), 32'h99);
        counts(1);
        check("t0_done", 32'(bus.done), 32'h1);
        check("t0_ovf", 32'(bus.overflow), 32'h1);

        // Clear beats start and count_in
        tgt = 8'hFF;
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        counts(42);
        check("t5_42", 32'(bus.digits), 32'h42);
        cycle(1, 1, 1, 0, 1);
        check("t5_clr", 32'(bus.digits), 32'h00);
        check("t5_idle", 32'(bus.state), 32'(ST_IDLE));
        cycle(1, 0, 1, 0, 1);
        check("t5_noinc", 32'(bus.digits), 32'h00);
        check("t5_run", 32'(bus.state), 32'(ST_RUN));

        // Reset mid-run
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);
        counts(37);
        check("t6_37", 32'(bus.digits), 32'h37);
        cycle(0, 0, 0, 0, 0);
        check("t6_rst", 32'(bus.digits), 32'h00);
        check("t6_rst_busy", 32'(bus.busy), 32'h0);
        cycle(1, 0, 1, 0, 1);
        cycle(1, 0, 1, 0, 1);
        check("t6_01", 32'(bus.digits), 32'h01);

        // Random commands and targets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 3) == 0) tgt = W'($urandom);
                else tgt = to_bcd(int'($urandom_range(0, MODN - 1)));
            end
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
